ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Elastic EX→MEM pipeline stage directly downstream of the execute-stage ALU.
- Captures the ALU result (r, zero, carry, negative, overflow) together with the instruction's control bundle.
- Resolves branch conditions from the ALU flags and converts signed overflow into a precise exception.
- Decouples EX from MEM back-pressure through a 2-entry skid buffer with valid/ready handshakes.

Parameters:
- EXC_OV, 5'h0C, exception code reported for arithmetic overflow (MIPS Ov).
- CNT_W, 32, width of the back-pressure stall counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous squash of all buffered entries and trap hold.
- in_valid  in  1  EX presents an entry.
- in_ready  out  1  stage can accept an entry; registered.
- in_pc  in  32  PC of the instruction.
- in_r  in  32  ALU result r.
- in_zero, in_carry, in_negative, in_overflow  in  1 each  ALU flags.
- in_ovf_trap  in  1  instruction traps on signed overflow (add/sub/addi).
- in_br_type  in  2  00 none, 01 beq (zero), 10 bne (~zero), 11 bgez (~negative).
- in_rd  in  5  destination register.
- in_reg_we, in_mem_we, in_mem_re  in  1 each  writeback / store / load enables.
- in_store_data  in  32  store data.
- out_valid  out  1  entry available to MEM.
- out_ready  in  1  MEM accepts.
- out_pc, out_r, out_store_data  out  32  registered copies.
- out_rd  out  5  registered copy.
- out_reg_we, out_mem_we, out_mem_re, out_carry  out  1 each  registered copies.
- out_br_taken  out  1  resolved branch decision.
- out_exc  out  1  entry carries an exception.
- out_exc_code  out  5  EXC_OV when out_exc, else 0.
- stall_cnt  out  CNT_W  count of cycles with out_valid & ~out_ready.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, in_ready=1, all out_* data=0, out_exc=0, stall_cnt=0, skid empty, state=RUN.
- Storage:
  - main register drives out_*.
  - skid register holds one entry.
  - in_ready = ~skid_full & (state==RUN) & ~flush_d; registered, so it may lag by one cycle.
  - Skid absorbs the one entry accepted while in_ready was still high.
- Accept: in_valid & in_ready. Entry goes to main if main is empty or being drained this cycle (out_valid & out_ready); otherwise to skid.
- Drain: on out_valid & out_ready, skid (if full) moves to main in the same cycle; else main empties unless refilled by a simultaneous accept.
- Latency:
  - 1 cycle EX→out_valid when empty.
  - Full throughput, 1 entry/cycle, with out_ready held high.
- Ordering: strict FIFO; no entry is ever dropped or duplicated except by flush.
- Transformation at capture:
  - br_taken = per in_br_type; 0 for type 00.
  - trap = in_ovf_trap & in_overflow.
  - When trap: reg_we, mem_we, mem_re and br_taken are forced 0; exc=1; exc_code=EXC_OV; r is stored unchanged.
  - in_overflow without in_ovf_trap (addu/subu) has no effect.
- State machine:
  - RUN → TRAP_HOLD on accepting a trapping entry.
  - In TRAP_HOLD: in_ready=0; already-buffered entries still drain normally.
  - TRAP_HOLD → RUN only on flush.
- Flush:
  - Next edge: out_valid=0, skid empty, state=RUN; stall_cnt is kept.
  - An input offered in the flush cycle is discarded.
  - in_ready is 0 in the cycle after flush (flush_d), then 1.
  - flush overrides a simultaneous accept or drain.
- stall_cnt: +1 per cycle with out_valid & ~out_ready; saturates at all-ones (no wrap).
- Outputs hold stable while out_valid & ~out_ready.
- rst_n asserted mid-transfer: all state clears immediately, with no partial output.

Test Plan:
- Single entry, out_ready=1: in_r=32'h0000_0005, reg_we=1, rd=3 at cycle 0 → out_valid at cycle 1 with out_r=5, out_rd=3; out_valid=0 at cycle 2.
- Back-pressure: stream 4 entries (r=1,2,3,4), out_ready=0 for 3 cycles, then 1.
  - in_ready falls after the skid fills.
  - Outputs emerge in order 1,2,3,4 with none lost.
  - stall_cnt=3.
- Overflow trap: in_ovf_trap=1, in_overflow=1, reg_we=1, r=32'h8000_0000.
  - Output: out_exc=1, out_exc_code=5'h0C, out_reg_we=0, out_r=32'h8000_0000.
  - in_ready stays 0 until flush, then returns to 1 one cycle after.
- Unsigned overflow is benign: in_ovf_trap=0, in_overflow=1, reg_we=1 → out_exc=0, out_reg_we=1.
- Branch resolution:
  - bgez with negative=0 → out_br_taken=1; bgez with negative=1 → 0.
  - beq with zero=1 → 1; bne with zero=1 → 0.
- Flush and reset:
  - With main and skid full, assert flush together with in_valid → next cycle out_valid=0, the offered entry is discarded, stall_cnt unchanged.
  - Asserting rst_n=0 asynchronously mid-stream clears out_valid immediately.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: captures ALU result and control, resolves branches,
// turns trapping signed overflow into a precise exception, and uses a 2-entry skid buffer.
module ex_mem_stage #(
  parameter logic [4:0] EXC_OV = 5'h0C,
  parameter int         CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_r,
  input  logic             in_zero,
  input  logic             in_carry,
  input  logic             in_negative,
  input  logic             in_overflow,
  input  logic             in_ovf_trap,
  input  logic [1:0]       in_br_type,
  input  logic [4:0]       in_rd,
  input  logic             in_reg_we,
  input  logic             in_mem_we,
  input  logic             in_mem_re,
  input  logic [31:0]      in_store_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_r,
  output logic [31:0]      out_store_data,
  output logic [4:0]       out_rd,
  output logic             out_reg_we,
  output logic             out_mem_we,
  output logic             out_mem_re,
  output logic             out_carry,
  output logic             out_br_taken,
  output logic             out_exc,
  output logic [4:0]       out_exc_code,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN = 1'b0, TRAP_HOLD = 1'b1} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] r;
    logic [31:0] storeData;
    logic [4:0]  rd;
    logic        regWe;
    logic        memWe;
    logic        memRe;
    logic        carry;
    logic        brTaken;
    logic        exc;
    logic [4:0]  excCode;
  } entry_t;

  state_t           r_state;
  state_t           w_stateNext;
  entry_t           r_main;
  entry_t           r_skid;
  entry_t           w_capture;
  logic             r_mainValid;
  logic             r_skidValid;
  logic             r_flushD;
  logic [CNT_W-1:0] r_stallCnt;
  logic             w_trap;
  logic             w_brRaw;
  logic             w_accept;
  logic             w_drain;

  // in_ready depends only on flops, so EX never sees a combinational path from MEM
  assign in_ready = ~r_skidValid & (r_state == RUN) & ~r_flushD;
  assign w_accept = in_valid & in_ready & ~flush;
  assign w_drain  = r_mainValid & out_ready;

  always_comb begin
    w_trap = in_ovf_trap & in_overflow;
    case (in_br_type)
      2'b01:   w_brRaw = in_zero;
      2'b10:   w_brRaw = ~in_zero;
      2'b11:   w_brRaw = ~in_negative;
      default: w_brRaw = 1'b0;
    endcase
    w_capture.pc        = in_pc;
    w_capture.r         = in_r;
    w_capture.storeData = in_store_data;
    w_capture.rd        = in_rd;
    w_capture.carry     = in_carry;
    w_capture.regWe     = in_reg_we & ~w_trap;
    w_capture.memWe     = in_mem_we & ~w_trap;
    w_capture.memRe     = in_mem_re & ~w_trap;
    w_capture.brTaken   = w_brRaw & ~w_trap;
    w_capture.exc       = w_trap;
    w_capture.excCode   = w_trap ? EXC_OV : 5'd0;
  end

  always_comb begin
    w_stateNext = r_state;
    if (flush)
      w_stateNext = RUN;
    else if (w_accept & w_trap)
      w_stateNext = TRAP_HOLD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= RUN;
      r_flushD <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_flushD <= flush;
    end
  end

  // Skid only fills when main is held; a draining main is refilled from skid first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mainValid <= 1'b0;
      r_skidValid <= 1'b0;
      r_main      <= '0;
      r_skid      <= '0;
    end else if (flush) begin
      r_mainValid <= 1'b0;
      r_skidValid <= 1'b0;
    end else if (w_drain) begin
      if (r_skidValid) begin
        r_main      <= r_skid;
        r_skidValid <= w_accept;
        if (w_accept)
          r_skid <= w_capture;
      end else if (w_accept) begin
        r_main <= w_capture;
      end else begin
        r_mainValid <= 1'b0;
      end
    end else if (w_accept) begin
      if (r_mainValid) begin
        r_skid      <= w_capture;
        r_skidValid <= 1'b1;
      end else begin
        r_main      <= w_capture;
        r_mainValid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stallCnt <= '0;
    else if (r_mainValid & ~out_ready & ~&r_stallCnt)
      r_stallCnt <= r_stallCnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign out_valid      = r_mainValid;
  assign out_pc         = r_main.pc;
  assign out_r          = r_main.r;
  assign out_store_data = r_main.storeData;
  assign out_rd         = r_main.rd;
  assign out_reg_we     = r_main.regWe;
  assign out_mem_we     = r_main.memWe;
  assign out_mem_re     = r_main.memRe;
  assign out_carry      = r_main.carry;
  assign out_br_taken   = r_main.brTaken;
  assign out_exc        = r_main.exc;
  assign out_exc_code   = r_main.excCode;
  assign stall_cnt      = r_stallCnt;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: scoreboard queue of expected entries plus
// directed checks on latency, back-pressure, traps, branches, flush and async reset.
module tb_ex_mem_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] r;
    logic [31:0] storeData;
    logic [4:0]  rd;
    logic        regWe;
    logic        memWe;
    logic        memRe;
    logic        carry;
    logic        brTaken;
    logic        exc;
    logic [4:0]  excCode;
  } expT;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_r;
  logic        in_zero;
  logic        in_carry;
  logic        in_negative;
  logic        in_overflow;
  logic        in_ovf_trap;
  logic [1:0]  in_br_type;
  logic [4:0]  in_rd;
  logic        in_reg_we;
  logic        in_mem_we;
  logic        in_mem_re;
  logic [31:0] in_store_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_r;
  logic [31:0] out_store_data;
  logic [4:0]  out_rd;
  logic        out_reg_we;
  logic        out_mem_we;
  logic        out_mem_re;
  logic        out_carry;
  logic        out_br_taken;
  logic        out_exc;
  logic [4:0]  out_exc_code;
  logic [31:0] stall_cnt;

  int  errors = 0;
  int  checks = 0;
  int  popCount = 0;
  expT sbQ[$];
  expT sbHead;

  ex_mem_stage #(.EXC_OV(5'h0C), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_r(in_r),
    .in_zero(in_zero), .in_carry(in_carry), .in_negative(in_negative),
    .in_overflow(in_overflow), .in_ovf_trap(in_ovf_trap),
    .in_br_type(in_br_type), .in_rd(in_rd),
    .in_reg_we(in_reg_we), .in_mem_we(in_mem_we), .in_mem_re(in_mem_re),
    .in_store_data(in_store_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_r(out_r), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_reg_we(out_reg_we), .out_mem_we(out_mem_we),
    .out_mem_re(out_mem_re), .out_carry(out_carry),
    .out_br_taken(out_br_taken), .out_exc(out_exc),
    .out_exc_code(out_exc_code), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one EX entry; the less interesting fields are derived from r for variety
  task automatic applyStimulus(input logic valid, input logic [31:0] r, input logic [4:0] rd,
                               input logic regWe, input logic ovfTrap, input logic overflow,
                               input logic [1:0] brType, input logic zero, input logic negative);
    in_valid      = valid;
    in_r          = r;
    in_rd         = rd;
    in_reg_we     = regWe;
    in_ovf_trap   = ovfTrap;
    in_overflow   = overflow;
    in_br_type    = brType;
    in_zero       = zero;
    in_negative   = negative;
    in_pc         = 32'h0000_0400 + {r[29:0], 2'b00};
    in_store_data = ~r;
    in_carry      = r[0];
    in_mem_we     = r[2];
    in_mem_re     = r[1];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model of what the stage should present for the entry currently driven
  function automatic expT buildExpected();
    expT e;
    logic trap;
    logic br;
    trap = in_ovf_trap & in_overflow;
    case (in_br_type)
      2'b01:   br = in_zero;
      2'b10:   br = ~in_zero;
      2'b11:   br = ~in_negative;
      default: br = 1'b0;
    endcase
    e.pc        = in_pc;
    e.r         = in_r;
    e.storeData = in_store_data;
    e.rd        = in_rd;
    e.carry     = in_carry;
    e.regWe     = trap ? 1'b0 : in_reg_we;
    e.memWe     = trap ? 1'b0 : in_mem_we;
    e.memRe     = trap ? 1'b0 : in_mem_re;
    e.brTaken   = trap ? 1'b0 : br;
    e.exc       = trap;
    e.excCode   = trap ? 5'h0C : 5'h00;
    return e;
  endfunction

  // Scoreboard: compare the head against the outputs whenever out_valid, pop on handshake,
  // push on input handshake; flush and reset discard everything buffered
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      sbQ.delete();
    end else begin
      if (out_valid) begin
        if (sbQ.size() == 0) begin
          checkOutput("sb_unexpected_valid", 32'(out_valid), 32'd0);
        end else begin
          sbHead = sbQ[0];
          checkOutput("sb_pc", out_pc, sbHead.pc);
          checkOutput("sb_r", out_r, sbHead.r);
          checkOutput("sb_store_data", out_store_data, sbHead.storeData);
          checkOutput("sb_rd", 32'(out_rd), 32'(sbHead.rd));
          checkOutput("sb_ctrl", {26'd0, out_reg_we, out_mem_we, out_mem_re, out_carry, out_br_taken, out_exc},
                      {26'd0, sbHead.regWe, sbHead.memWe, sbHead.memRe, sbHead.carry, sbHead.brTaken, sbHead.exc});
          checkOutput("sb_exc_code", 32'(out_exc_code), 32'(sbHead.excCode));
          if (out_ready) begin
            void'(sbQ.pop_front());
            popCount++;
          end
        end
      end
      if (in_valid && in_ready)
        sbQ.push_back(buildExpected());
    end
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_stall_cnt", stall_cnt, 32'd0);
    checkOutput("reset_out_r", out_r, 32'd0);
    checkOutput("reset_out_exc", 32'(out_exc), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single entry, one-cycle latency
    applyStimulus(1'b1, 32'h0000_0005, 5'd3, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("single_out_valid", 32'(out_valid), 32'd1);
    checkOutput("single_out_r", out_r, 32'd5);
    checkOutput("single_out_rd", 32'(out_rd), 32'd3);
    tick();
    checkOutput("single_out_valid_gone", 32'(out_valid), 32'd0);
    checkOutput("single_stall_cnt", stall_cnt, 32'd0);

    // Back-pressure: four entries, three stalled cycles
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'd1, 5'd1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'd2, 5'd2, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 32'd3, 5'd3, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    checkOutput("bp_hold_r", out_r, 32'd1);
    tick();
    out_ready = 1'b1;
    tick();
    checkOutput("bp_in_ready_back", 32'(in_ready), 32'd1);
    checkOutput("bp_second_r", out_r, 32'd2);
    tick();
    applyStimulus(1'b1, 32'd4, 5'd4, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    repeat (3) tick();
    checkOutput("bp_stall_cnt", stall_cnt, 32'd3);
    checkOutput("bp_pop_count", 32'(popCount), 32'd5);
    checkOutput("bp_queue_empty", 32'(sbQ.size()), 32'd0);

    // Trapping overflow: exception, write suppressed, stage holds until flush
    applyStimulus(1'b1, 32'h8000_0000, 5'd7, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h0000_DEAD, 5'd9, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("trap_out_exc", 32'(out_exc), 32'd1);
    checkOutput("trap_exc_code", 32'(out_exc_code), 32'h0C);
    checkOutput("trap_reg_we", 32'(out_reg_we), 32'd0);
    checkOutput("trap_out_r", out_r, 32'h8000_0000);
    checkOutput("trap_in_ready", 32'(in_ready), 32'd0);
    tick();
    checkOutput("trap_hold_in_ready", 32'(in_ready), 32'd0);
    tick();
    checkOutput("trap_hold_in_ready2", 32'(in_ready), 32'd0);
    checkOutput("trap_hold_no_output", 32'(out_valid), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("trap_flush_d_in_ready", 32'(in_ready), 32'd0);
    tick();
    checkOutput("trap_released_in_ready", 32'(in_ready), 32'd1);
    checkOutput("trap_flush_no_output", 32'(out_valid), 32'd0);

    // Unsigned overflow has no effect
    applyStimulus(1'b1, 32'hFFFF_FFFE, 5'd4, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1);
    tick();
    checkOutput("benign_out_exc", 32'(out_exc), 32'd0);
    checkOutput("benign_reg_we", 32'(out_reg_we), 32'd1);

    // Branch resolution, back to back at full throughput
    applyStimulus(1'b1, 32'd10, 5'd0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
    tick();
    checkOutput("br_bgez_pos", 32'(out_br_taken), 32'd1);
    applyStimulus(1'b1, 32'd11, 5'd0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1);
    tick();
    checkOutput("br_bgez_neg", 32'(out_br_taken), 32'd0);
    applyStimulus(1'b1, 32'd12, 5'd0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
    tick();
    checkOutput("br_beq_zero", 32'(out_br_taken), 32'd1);
    applyStimulus(1'b1, 32'd13, 5'd0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
    tick();
    checkOutput("br_bne_zero", 32'(out_br_taken), 32'd0);
    checkOutput("br_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();

    // Flush with main and skid full while an entry is offered
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'd21, 5'd1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'd22, 5'd2, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    checkOutput("fl_full_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 32'd23, 5'd3, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("fl_out_valid", 32'(out_valid), 32'd0);
    checkOutput("fl_stall_cnt", stall_cnt, 32'd4);
    checkOutput("fl_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    checkOutput("fl_in_ready_back", 32'(in_ready), 32'd1);
    checkOutput("fl_discarded", 32'(out_valid), 32'd0);

    // Asynchronous reset in the middle of a cycle
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'd31, 5'd5, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("ar_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_out_valid", 32'(out_valid), 32'd0);
    checkOutput("ar_in_ready", 32'(in_ready), 32'd1);
    checkOutput("ar_stall_cnt", stall_cnt, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) tick();
    checkOutput("end_out_valid", 32'(out_valid), 32'd0);
    checkOutput("end_queue_empty", 32'(sbQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
